// File: rtl/ahb_sram_slave_pkg.sv
// Shared AMBA AHB constants used by the SRAM slave and its lane decoder.
// HTRANS_*: transfer type, HSIZE_*: transfer size, HRESP_*: response, HBURST_*: burst type.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

endpackage

// File: rtl/ahb_lane_dec.sv
// AHB byte-lane decoder (little-endian, 32-bit data bus).
// Ports:
//   hsize_i   - AHB transfer size
//   addr_i    - low two bits of the byte address
//   be_o      - active-high byte-lane enables, bit i = lane i
//   illegal_o - misaligned transfer or size wider than a word
module ahb_lane_dec
  import ahb_sram_slave_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] be_o,
  output logic       illegal_o
);

  always_comb begin
    be_o      = 4'b0000;
    illegal_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: begin
        be_o = 4'b0001 << addr_i;
      end
      HSIZE_HWORD: begin
        be_o      = addr_i[1] ? 4'b1100 : 4'b0011;
        illegal_o = addr_i[0];
      end
      HSIZE_WORD: begin
        be_o      = 4'b1111;
        illegal_o = (addr_i != 2'b00);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave driving an external asynchronous 32-bit SRAM with programmable wait states.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   ahbsi_*         - AHB slave inputs (select, address phase, write data)
//   ahbso_*         - AHB slave outputs (hready, hresp, hrdata); hready is also the bus hready
//   sram_addr       - SRAM word address
//   sram_dq_o/_i    - SRAM write/read data; sram_dq_oe enables the pad drivers
//   sram_ce_n/oe_n/we_n/be_n - active-low SRAM strobes and byte enables
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ahbsi_hsel,
  input  logic [31:0]       ahbsi_haddr,
  input  logic              ahbsi_hwrite,
  input  logic [1:0]        ahbsi_htrans,
  input  logic [2:0]        ahbsi_hsize,
  input  logic [2:0]        ahbsi_hburst,
  input  logic [31:0]       ahbsi_hwdata,
  output logic              ahbso_hready,
  output logic [1:0]        ahbso_hresp,
  output logic [31:0]       ahbso_hrdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StErr1, StErr2} state_e;

  localparam logic [3:0] RdWait = 4'(RD_WAIT);
  localparam logic [3:0] WrWait = 4'(WR_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic [3:0] dec_be;
  logic       dec_illegal;
  logic       ready;
  logic       accept;

  // Burst type and address bits above the SRAM range play no part in addressing.
  logic unused_bits;
  assign unused_bits = ^{ahbsi_hburst, ahbsi_haddr[31:ADDR_W+2]};

  ahb_lane_dec u_lane_dec (
    .hsize_i   (ahbsi_hsize),
    .addr_i    (ahbsi_haddr[1:0]),
    .be_o      (dec_be),
    .illegal_o (dec_illegal)
  );

  // Kept separate from the main block so accept does not feed back into it.
  always_comb begin
    ready = 1'b1;
    unique case (state_q)
      StRd:    ready = (cnt_q == RdWait);
      StWr:    ready = (cnt_q == WrWait);
      StErr1:  ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  assign accept = ahbsi_hsel && ready &&
                  ((ahbsi_htrans == HTRANS_NONSEQ) || (ahbsi_htrans == HTRANS_SEQ));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    be_d        = be_q;
    hrdata_d    = hrdata_q;
    ahbso_hresp = HRESP_OKAY;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_be_n   = 4'hF;
    sram_dq_oe  = 1'b0;
    sram_dq_o   = 32'h0;

    unique case (state_q)
      StRd: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = ~be_q;
        // Capture one edge before completion so hrdata is stable while hready is high.
        if (cnt_q == RdWait - 4'd1) hrdata_d = sram_dq_i;
      end
      StWr: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_dq_o  = ahbsi_hwdata;
        sram_be_n  = ~be_q;
        // we_n releases in the final cycle so data is held past the strobe.
        sram_we_n  = (cnt_q == WrWait);
      end
      StErr1: begin
        ahbso_hresp = HRESP_ERROR;
        state_d     = StErr2;
      end
      StErr2: begin
        ahbso_hresp = HRESP_ERROR;
      end
      default: ;
    endcase

    if (ready) begin
      state_d = StIdle;
      if (accept) begin
        cnt_d  = 4'd0;
        addr_d = ahbsi_haddr[ADDR_W+1:2];
        be_d   = dec_be;
        if (dec_illegal)       state_d = StErr1;
        else if (ahbsi_hwrite) state_d = StWr;
        else                   state_d = StRd;
      end
    end else if ((state_q == StRd) || (state_q == StWr)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      be_q     <= 4'd0;
      hrdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign ahbso_hready = ready;
  assign ahbso_hrdata = hrdata_q;
  assign sram_addr    = addr_q;

endmodule
